// File: rtl/core_pkg.sv
// Shared opcode, instruction field and FSM definitions for param_exec_core.
package core_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_REM = 4'd4;
  localparam logic [3:0] OP_SGT = 4'd5;
  localparam logic [3:0] OP_SEQ = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_NOP = 4'd8;

  localparam int OP_LSB       = 28;
  localparam int IMM_SEL_BIT  = 27;
  localparam int UNSIGNED_BIT = 26;
  localparam int RD_LSB       = 21;
  localparam int RS1_LSB      = 16;
  localparam int RS2_LSB      = 11;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    EXEC,
    WB
  } stateT;

  function automatic int regAddrWidth(input int numRegs);
    return (numRegs > 1) ? $clog2(numRegs) : 1;
  endfunction

endpackage

// File: rtl/core_divider.sv
// Restoring divider, one quotient bit per cycle; zero divisor and signed MIN/-1
// are resolved in the start cycle.
module core_divider #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              unsigned_en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MinVal = {1'b1, {(DATA_W-1){1'b0}}};

  logic [CW-1:0]     count;
  logic [DATA_W-1:0] quoReg, remReg, divisorMag;
  logic [DATA_W-1:0] aMag, bMag, nextQuo, nextRem;
  logic [DATA_W:0]   partial, diff;
  logic              aNeg, bNeg, negQuo, negRem;

  assign quotient  = quoReg;
  assign remainder = remReg;

  // Magnitudes for signed operands, plus one restoring step on the working pair.
  always_comb begin
    aNeg    = !unsigned_en && a[DATA_W-1];
    bNeg    = !unsigned_en && b[DATA_W-1];
    aMag    = aNeg ? -a : a;
    bMag    = bNeg ? -b : b;
    partial = {remReg, quoReg[DATA_W-1]};
    diff    = partial - {1'b0, divisorMag};
    if (!diff[DATA_W]) begin
      nextRem = diff[DATA_W-1:0];
      nextQuo = {quoReg[DATA_W-2:0], 1'b1};
    end else begin
      nextRem = partial[DATA_W-1:0];
      nextQuo = {quoReg[DATA_W-2:0], 1'b0};
    end
  end

  // The final step applies the sign fix-up so results are ready with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      quoReg     <= '0;
      remReg     <= '0;
      divisorMag <= '0;
      negQuo     <= 1'b0;
      negRem     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        if (b == '0) begin
          quoReg <= '1;
          remReg <= a;
          busy   <= 1'b0;
          done   <= 1'b1;
        end else if (!unsigned_en && a == MinVal && b == '1) begin
          quoReg <= MinVal;
          remReg <= '0;
          busy   <= 1'b0;
          done   <= 1'b1;
        end else begin
          quoReg     <= aMag;
          remReg     <= '0;
          divisorMag <= bMag;
          negQuo     <= aNeg ^ bNeg;
          negRem     <= aNeg;
          count      <= CW'(DATA_W);
          busy       <= 1'b1;
        end
      end else if (busy) begin
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          busy   <= 1'b0;
          done   <= 1'b1;
          quoReg <= negQuo ? -nextQuo : nextQuo;
          remReg <= negRem ? -nextRem : nextRem;
        end else begin
          quoReg <= nextQuo;
          remReg <= nextRem;
        end
      end
    end
  end

endmodule

// File: rtl/param_exec_core.sv
// Handshaked execution core: accept, decode, register read, execute, writeback.
// Define PARAM_EXEC_CORE_DIV_EN to build in the iterative divider for DIV/REM.
module param_exec_core
  import core_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  localparam int REG_AW  = regAddrWidth(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  stateT             state, nextState;
  logic [31:0]       instrReg;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] srcA, srcB, opA, opB, aluOut, result;
  logic [DATA_W-1:0] divQuotient, divRemainder;
  logic [3:0]        op;
  logic [REG_AW-1:0] rdAddr, rs1Addr, rs2Addr;
  logic              immSel, isUnsigned, isDiv, illegal, writeEn, divWait;
  logic              unusedFieldBits;

  assign op         = instrReg[OP_LSB +: 4];
  assign immSel     = instrReg[IMM_SEL_BIT];
  assign isUnsigned = instrReg[UNSIGNED_BIT];
  assign rdAddr     = instrReg[RD_LSB +: REG_AW];
  assign rs1Addr    = instrReg[RS1_LSB +: REG_AW];
  assign rs2Addr    = instrReg[RS2_LSB +: REG_AW];
  // Upper register-field bits are ignored when NUM_REGS < 32.
  assign unusedFieldBits = ^instrReg;

  assign srcA = regs[rs1Addr];
  assign srcB = immSel ? DATA_W'($signed(instrReg[15:0])) : regs[rs2Addr];

`ifdef PARAM_EXEC_CORE_DIV_EN
  localparam bit DivEnabled = 1'b1;
  logic divStart, divBusy, divDone;

  assign divStart = (state == READ) && isDiv;
  assign divWait  = isDiv && (divBusy || !divDone);

  core_divider #(.DATA_W(DATA_W)) uDivider (
    .clk         (clk),
    .reset       (reset),
    .start       (divStart),
    .unsigned_en (isUnsigned),
    .a           (srcA),
    .b           (srcB),
    .busy        (divBusy),
    .done        (divDone),
    .quotient    (divQuotient),
    .remainder   (divRemainder)
  );
`else
  localparam bit DivEnabled = 1'b0;
  assign divWait      = 1'b0;
  assign divQuotient  = '0;
  assign divRemainder = '0;
`endif

  assign isDiv   = (op == OP_DIV) || (op == OP_REM);
  assign illegal = (op > OP_NOP) || (isDiv && !DivEnabled);
  assign writeEn = (state == WB) && !illegal && (op != OP_NOP) && (rdAddr != '0);

  assign instr_ready = (state == IDLE);
  assign busy        = !instr_ready;
  assign done        = (state == WB);
  assign error       = (state == WB) && illegal;
  assign dbg_data    = regs[dbg_addr];

  always_comb begin
    aluOut = '0;
    case (op)
      OP_ADD:  aluOut = opA + opB;
      OP_SUB:  aluOut = opA - opB;
      OP_MUL:  aluOut = opA * opB;
      OP_DIV:  aluOut = divQuotient;
      OP_REM:  aluOut = divRemainder;
      OP_SGT:  aluOut = DATA_W'(isUnsigned ? (opA > opB) : ($signed(opA) > $signed(opB)));
      OP_SEQ:  aluOut = DATA_W'(opA == opB);
      OP_SLT:  aluOut = DATA_W'(isUnsigned ? (opA < opB) : ($signed(opA) < $signed(opB)));
      default: aluOut = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // EXEC only lingers while a divide is still iterating.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (instr_valid) nextState = DECODE;
      DECODE:  nextState = READ;
      READ:    nextState = EXEC;
      EXEC:    if (!divWait) nextState = WB;
      WB:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instrReg <= '0;
      opA      <= '0;
      opB      <= '0;
      result   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == IDLE && instr_valid) instrReg <= instr;
      if (state == READ) begin
        opA <= srcA;
        opB <= srcB;
      end
      if (state == EXEC) result <= aluOut;
      if (writeEn) regs[rdAddr] <= result;
    end
  end

endmodule
